// File: rtl/axi_pkg.sv
// axi_pkg: AXI response/burst encodings, engine states and burst legality.
// AXI_RAM_WRAP_EN enables WRAP bursts; without it WRAP behaves as INCR.
package axi_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
`ifdef AXI_RAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;
  // Reserved bursts, and WRAP with a non-power-of-two beat count, are rejected outright.
  function automatic logic burst_bad(input logic [1:0] b, input logic [7:0] len);
    return b == 2'b11 || (WRAP_EN && b == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction
endpackage

// File: rtl/axi_ram_addr_gen.sv
// axi_ram_addr_gen: next beat address and RAM window check for one engine.
// WRAP windows are built only when AXI_RAM_WRAP_EN is defined.
module axi_ram_addr_gen import axi_pkg::*; #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = 10
) (
  input  logic [31:0]   i_addr,
  input  logic [1:0]    i_burst,
`ifdef AXI_RAM_WRAP_EN
  input  logic [7:0]    i_len,
`endif
  output logic [31:0]   o_next,
  output logic          o_in_range,
  output logic [AW-1:0] o_idx
);
  logic [31:0] w_off;
  assign w_off = i_addr - ADDR_BASE;
  assign o_in_range = w_off < 32'(DEPTH_WORDS * 4);
  assign o_idx = w_off[AW+1:2];
`ifdef AXI_RAM_WRAP_EN
  logic [31:0] w_mask;
  assign w_mask = {22'd0, i_len, 2'b11};
  assign o_next = i_burst == BURST_FIXED ? i_addr :
                  i_burst == BURST_WRAP ? (i_addr & ~w_mask) | ((i_addr + 32'd4) & w_mask) :
                  i_addr + 32'd4;
`else
  assign o_next = i_burst == BURST_FIXED ? i_addr : i_addr + 32'd4;
`endif
endmodule

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 slave over a byte-strobed 32-bit RAM with independent write/read engines.
// AXI_RAM_WRAP_EN adds WRAP burst support.
module axi_ram_slave import axi_pkg::*; #(
  parameter int ID_WIDTH = 2,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [ID_WIDTH-1:0] WR_ADDR_ID,
  input  logic [31:0]         WR_ADDR,
  input  logic [7:0]          WR_ADDR_LEN,
  input  logic [1:0]          WR_ADDR_BURST,
  input  logic                WR_ADDR_VALID,
  output logic                WR_ADDR_READY,
  input  logic [31:0]         WR_DATA,
  input  logic [3:0]          WR_STRB,
  input  logic                WR_DATA_LAST,
  input  logic                WR_DATA_VALID,
  output logic                WR_DATA_READY,
  output logic [ID_WIDTH-1:0] WR_BACK_ID,
  output logic [1:0]          WR_BACK_RESP,
  output logic                WR_BACK_VALID,
  input  logic                WR_BACK_READY,
  input  logic [ID_WIDTH-1:0] RD_ADDR_ID,
  input  logic [31:0]         RD_ADDR,
  input  logic [7:0]          RD_ADDR_LEN,
  input  logic [1:0]          RD_ADDR_BURST,
  input  logic                RD_ADDR_VALID,
  output logic                RD_ADDR_READY,
  output logic [ID_WIDTH-1:0] RD_BACK_ID,
  output logic [31:0]         RD_DATA,
  output logic [1:0]          RD_DATA_RESP,
  output logic                RD_DATA_LAST,
  output logic                RD_DATA_VALID,
  input  logic                RD_DATA_READY
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [3:0][7:0] r_mem [DEPTH_WORDS];
  wr_state_t r_wstate;
  rd_state_t r_rstate;
  logic [ID_WIDTH-1:0] r_wid, r_rid;
  logic [31:0] r_waddr, r_raddr, w_wnext, w_rnext;
  logic [7:0] r_wlen, r_rlen, r_rbeat;
  logic [1:0] r_wburst, r_rburst;
  logic [8:0] r_wcnt;
  logic r_wdec, r_wslv, r_wbad, r_rbad, w_win, w_rin, w_wbeat, w_wlive, w_we, w_wdec_n;
  logic [AW-1:0] w_widx, w_ridx;
  axi_ram_addr_gen #(.ADDR_BASE(ADDR_BASE), .DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_wgen (
    .i_addr(r_waddr), .i_burst(r_wburst),
`ifdef AXI_RAM_WRAP_EN
    .i_len(r_wlen),
`endif
    .o_next(w_wnext), .o_in_range(w_win), .o_idx(w_widx));
  axi_ram_addr_gen #(.ADDR_BASE(ADDR_BASE), .DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_rgen (
    .i_addr(r_raddr), .i_burst(r_rburst),
`ifdef AXI_RAM_WRAP_EN
    .i_len(r_rlen),
`endif
    .o_next(w_rnext), .o_in_range(w_rin), .o_idx(w_ridx));
  assign w_wbeat = r_wstate == W_DATA && WR_DATA_VALID && WR_DATA_READY;
  // Beats past len+1 without LAST are swallowed but never written.
  assign w_wlive = r_wcnt <= {1'b0, r_wlen};
  assign w_we = w_wbeat && w_wlive && w_win && !r_wbad && !RST;
  assign w_wdec_n = r_wdec | (w_wlive & ~w_win);
  always_ff @(posedge CLK) begin
    if (w_we)
      for (int b = 0; b < 4; b++)
        if (WR_STRB[b]) r_mem[w_widx][b] <= WR_DATA[8*b +: 8];
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wstate <= W_IDLE;
      WR_ADDR_READY <= 1'b0;
      WR_DATA_READY <= 1'b0;
      WR_BACK_VALID <= 1'b0;
      WR_BACK_ID <= '0;
      WR_BACK_RESP <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: if (WR_ADDR_VALID && WR_ADDR_READY) begin
          r_wid <= WR_ADDR_ID;
          r_waddr <= WR_ADDR;
          r_wlen <= WR_ADDR_LEN;
          r_wburst <= WR_ADDR_BURST;
          r_wcnt <= '0;
          r_wdec <= 1'b0;
          r_wslv <= 1'b0;
          r_wbad <= burst_bad(WR_ADDR_BURST, WR_ADDR_LEN);
          WR_ADDR_READY <= 1'b0;
          WR_DATA_READY <= 1'b1;
          r_wstate <= W_DATA;
        end else WR_ADDR_READY <= 1'b1;
        W_DATA: if (w_wbeat) begin
          r_wcnt <= r_wcnt + {8'd0, r_wcnt != 9'h1ff};
          r_waddr <= w_wnext;
          r_wdec <= w_wdec_n;
          r_wslv <= r_wslv | ~w_wlive;
          if (WR_DATA_LAST) begin
            WR_DATA_READY <= 1'b0;
            WR_BACK_VALID <= 1'b1;
            WR_BACK_ID <= r_wid;
            WR_BACK_RESP <= w_wdec_n ? RESP_DECERR :
                            (r_wslv || r_wbad || r_wcnt != {1'b0, r_wlen}) ? RESP_SLVERR : RESP_OKAY;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: if (WR_BACK_READY) begin
          WR_BACK_VALID <= 1'b0;
          WR_ADDR_READY <= 1'b1;
          r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rstate <= R_IDLE;
      RD_ADDR_READY <= 1'b0;
      RD_DATA_VALID <= 1'b0;
      RD_DATA_LAST <= 1'b0;
      RD_DATA <= '0;
      RD_DATA_RESP <= RESP_OKAY;
      RD_BACK_ID <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (RD_ADDR_VALID && RD_ADDR_READY) begin
          r_rid <= RD_ADDR_ID;
          r_raddr <= RD_ADDR;
          r_rlen <= RD_ADDR_LEN;
          r_rburst <= RD_ADDR_BURST;
          r_rbeat <= '0;
          r_rbad <= burst_bad(RD_ADDR_BURST, RD_ADDR_LEN);
          RD_ADDR_READY <= 1'b0;
          r_rstate <= R_FETCH;
        end else RD_ADDR_READY <= 1'b1;
        R_FETCH: begin
          RD_DATA <= (w_rin && !r_rbad) ? r_mem[w_ridx] : '0;
          RD_DATA_RESP <= !w_rin ? RESP_DECERR : r_rbad ? RESP_SLVERR : RESP_OKAY;
          RD_DATA_LAST <= r_rbeat == r_rlen;
          RD_BACK_ID <= r_rid;
          RD_DATA_VALID <= 1'b1;
          r_rstate <= R_DATA;
        end
        R_DATA: if (RD_DATA_READY) begin
          RD_DATA_VALID <= 1'b0;
          RD_DATA_LAST <= 1'b0;
          if (RD_DATA_LAST) begin
            RD_ADDR_READY <= 1'b1;
            r_rstate <= R_IDLE;
          end else begin
            r_rbeat <= r_rbeat + 8'd1;
            r_raddr <= w_rnext;
            r_rstate <= R_FETCH;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed AXI transactions checked against a word-array model of the RAM.
module tb_axi_ram_slave;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int DEPTH = 16;
`ifdef AXI_RAM_WRAP_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif
  logic CLK = 1'b0, RST = 1'b1;
  logic [1:0] WR_ADDR_ID = '0, WR_ADDR_BURST = '0, WR_BACK_ID, WR_BACK_RESP;
  logic [31:0] WR_ADDR = '0, WR_DATA = '0;
  logic [7:0] WR_ADDR_LEN = '0, RD_ADDR_LEN = '0;
  logic [3:0] WR_STRB = '0;
  logic WR_ADDR_VALID = 0, WR_ADDR_READY, WR_DATA_LAST = 0, WR_DATA_VALID = 0, WR_DATA_READY;
  logic WR_BACK_VALID, WR_BACK_READY = 1;
  logic [1:0] RD_ADDR_ID = '0, RD_ADDR_BURST = '0, RD_BACK_ID, RD_DATA_RESP;
  logic [31:0] RD_ADDR = '0, RD_DATA;
  logic RD_ADDR_VALID = 0, RD_ADDR_READY, RD_DATA_LAST, RD_DATA_VALID, RD_DATA_READY = 1;

  axi_ram_slave #(.ID_WIDTH(2), .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .WR_ADDR_ID(WR_ADDR_ID), .WR_ADDR(WR_ADDR), .WR_ADDR_LEN(WR_ADDR_LEN), .WR_ADDR_BURST(WR_ADDR_BURST),
    .WR_ADDR_VALID(WR_ADDR_VALID), .WR_ADDR_READY(WR_ADDR_READY),
    .WR_DATA(WR_DATA), .WR_STRB(WR_STRB), .WR_DATA_LAST(WR_DATA_LAST),
    .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_READY(WR_DATA_READY),
    .WR_BACK_ID(WR_BACK_ID), .WR_BACK_RESP(WR_BACK_RESP), .WR_BACK_VALID(WR_BACK_VALID), .WR_BACK_READY(WR_BACK_READY),
    .RD_ADDR_ID(RD_ADDR_ID), .RD_ADDR(RD_ADDR), .RD_ADDR_LEN(RD_ADDR_LEN), .RD_ADDR_BURST(RD_ADDR_BURST),
    .RD_ADDR_VALID(RD_ADDR_VALID), .RD_ADDR_READY(RD_ADDR_READY),
    .RD_BACK_ID(RD_BACK_ID), .RD_DATA(RD_DATA), .RD_DATA_RESP(RD_DATA_RESP), .RD_DATA_LAST(RD_DATA_LAST),
    .RD_DATA_VALID(RD_DATA_VALID), .RD_DATA_READY(RD_DATA_READY));

  always #5 CLK = ~CLK;

  typedef struct {logic [31:0] data; logic [1:0] resp; logic last; logic [1:0] id;} rbeat_t;
  typedef struct {logic [1:0] resp; logic [1:0] id;} bresp_t;
  rbeat_t exp_r[$];
  bresp_t exp_b[$];
  logic [31:0] rd_got[$];
  logic [31:0] mem [DEPTH];
  logic [1:0] b_got;
  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic bad_burst(input logic [1:0] b, input logic [7:0] len);
    return b == 2'b11 || (WEN && b == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Closed-form byte address of beat i.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i, input logic [1:0] b, input logic [7:0] len);
    logic [31:0] sz, lo;
    if (b == 2'b00) return a;
    if (WEN && b == 2'b10) begin
      sz = (32'(len) + 32'd1) * 32'd4;
      lo = a - a % sz;
      return lo + (a - lo + 32'(4 * i)) % sz;
    end
    return a + 32'(4 * i);
  endfunction

  function automatic logic in_rng(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'(DEPTH * 4);
  endfunction

  function automatic logic rdy(input int ch);
    return ch == 0 ? WR_ADDR_READY : ch == 1 ? WR_DATA_READY : RD_ADDR_READY;
  endfunction

  always @(negedge CLK) if (!RST) begin
    if (RD_DATA_VALID) begin
      if (exp_r.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got beat %h want no beat", RD_DATA);
      end else begin
        chk("rd_data", RD_DATA, exp_r[0].data);
        chk("rd_resp", 32'(RD_DATA_RESP), 32'(exp_r[0].resp));
        chk("rd_last", 32'(RD_DATA_LAST), 32'(exp_r[0].last));
        chk("rd_id", 32'(RD_BACK_ID), 32'(exp_r[0].id));
        if (RD_DATA_READY) begin
          rd_got.push_back(RD_DATA);
          void'(exp_r.pop_front());
        end
      end
    end
    if (WR_BACK_VALID) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got resp %b want no response", WR_BACK_RESP);
      end else begin
        chk("b_resp", 32'(WR_BACK_RESP), 32'(exp_b[0].resp));
        chk("b_id", 32'(WR_BACK_ID), 32'(exp_b[0].id));
        if (WR_BACK_READY) begin
          b_got = WR_BACK_RESP;
          void'(exp_b.pop_front());
        end
      end
    end
  end

  task automatic hs(input int ch, input string nm);
    int t = 0;
    @(negedge CLK);
    while (!rdy(ch) && t < 50) begin
      t++;
      @(negedge CLK);
    end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no READY want READY within 50 cycles", nm);
    end
    @(posedge CLK); #1;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0) && t < 300) begin
      t++;
      @(negedge CLK);
    end
    if (t >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d rd/%0d b pending want 0", exp_r.size(), exp_b.size());
      exp_r.delete(); exp_b.delete();
    end
    @(posedge CLK); #1;
  endtask

  task automatic wr(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                    input logic [3:0] strb, input int n, input logic [31:0] dbase, input int b_stall);
    logic bad, dec;
    logic [31:0] a, d;
    int w;
    bad = bad_burst(burst, len);
    dec = 0;
    for (int i = 0; i < n; i++) if (i <= int'(len)) begin
      a = beat_addr(addr, i, burst, len);
      d = dbase + 32'(i);
      if (!in_rng(a)) dec = 1;
      else if (!bad) begin
        w = int'((a - BASE) >> 2);
        for (int k = 0; k < 4; k++) if (strb[k]) mem[w][8*k +: 8] = d[8*k +: 8];
      end
    end
    exp_b.push_back('{dec ? 2'b11 : (bad || n != int'(len) + 1) ? 2'b10 : 2'b00, id});
    WR_BACK_READY = b_stall == 0;
    WR_ADDR_ID = id; WR_ADDR = addr; WR_ADDR_LEN = len; WR_ADDR_BURST = burst; WR_ADDR_VALID = 1;
    hs(0, "aw");
    WR_ADDR_VALID = 0;
    for (int i = 0; i < n; i++) begin
      WR_DATA = dbase + 32'(i); WR_STRB = strb; WR_DATA_LAST = i == n - 1; WR_DATA_VALID = 1;
      hs(1, "w");
    end
    WR_DATA_VALID = 0; WR_DATA_LAST = 0;
    if (b_stall > 0) begin
      repeat (b_stall) @(posedge CLK);
      #1 WR_BACK_READY = 1;
    end
    drain();
  endtask

  task automatic rd(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                    input int r_stall, input bit lat);
    logic bad;
    logic [31:0] a;
    bad = bad_burst(burst, len);
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, i, burst, len);
      if (!in_rng(a)) exp_r.push_back('{32'd0, 2'b11, i == int'(len), id});
      else if (bad) exp_r.push_back('{32'd0, 2'b10, i == int'(len), id});
      else exp_r.push_back('{mem[int'((a - BASE) >> 2)], 2'b00, i == int'(len), id});
    end
    rd_got.delete();
    RD_DATA_READY = r_stall == 0;
    RD_ADDR_ID = id; RD_ADDR = addr; RD_ADDR_LEN = len; RD_ADDR_BURST = burst; RD_ADDR_VALID = 1;
    hs(2, "ar");
    RD_ADDR_VALID = 0;
    if (lat) begin
      @(negedge CLK) chk("rd_lat_cycle1", 32'(RD_DATA_VALID), 32'd0);
      @(negedge CLK) chk("rd_lat_cycle2", 32'(RD_DATA_VALID), 32'd1);
    end
    if (r_stall > 0) begin
      repeat (r_stall) @(posedge CLK);
      #1 chk("rd_stall_valid", 32'(RD_DATA_VALID), 32'd1);
      RD_DATA_READY = 1;
    end
    drain();
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_ready"}, {29'd0, WR_ADDR_READY, WR_DATA_READY, RD_ADDR_READY}, 32'd0);
    chk({nm, "_valid"}, {29'd0, WR_BACK_VALID, RD_DATA_VALID, RD_DATA_LAST}, 32'd0);
    chk({nm, "_rdata"}, RD_DATA, 32'd0);
    chk({nm, "_resp_id"}, {24'd0, WR_BACK_RESP, WR_BACK_ID, RD_DATA_RESP, RD_BACK_ID}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK) chk_outs_zero("reset");
    @(posedge CLK); #1 RST = 0;
    wr(2'd0, BASE, 8'd15, 2'b01, 4'hF, 16, 32'h1111_0000, 0);
    wr(2'd2, BASE + 32'h10, 8'd3, 2'b01, 4'hF, 4, 32'd1, 0);
    chk("lit_incr_bresp", 32'(b_got), 32'd0);
    rd(2'd1, BASE + 32'h10, 8'd3, 2'b01, 0, 1);
    chk("lit_incr_beat0", rd_got[0], 32'd1);
    chk("lit_incr_beat3", rd_got[3], 32'd4);
    wr(2'd0, BASE, 8'd0, 2'b01, 4'hF, 1, 32'd0, 0);
    wr(2'd1, BASE, 8'd0, 2'b01, 4'b0010, 1, 32'hAABB_CCDD, 0);
    rd(2'd0, BASE, 8'd0, 2'b01, 0, 0);
    chk("lit_strobe", rd_got[0], 32'h0000_CC00);
    wr(2'd3, BASE + 32'h40, 8'd0, 2'b01, 4'hF, 1, 32'hDEAD_BEEF, 0);
    chk("lit_oor_bresp", 32'(b_got), 32'd3);
    rd(2'd2, BASE + 32'h40, 8'd0, 2'b01, 0, 0);
    chk("lit_oor_rdata", rd_got[0], 32'd0);
    rd(2'd0, BASE, 8'd0, 2'b01, 0, 0);
    chk("lit_oor_unchanged", rd_got[0], 32'h0000_CC00);
    rd(2'd1, BASE + 32'h3C, 8'd1, 2'b01, 0, 0);
    wr(2'd1, BASE + 32'h20, 8'd3, 2'b01, 4'hF, 3, 32'hA0, 3);
    chk("lit_short_bresp", 32'(b_got), 32'd2);
    rd(2'd2, BASE + 32'h20, 8'd3, 2'b01, 6, 0);
    chk("lit_short_beat2", rd_got[2], 32'hA2);
    wr(2'd0, BASE + 32'h30, 8'd1, 2'b01, 4'hF, 3, 32'hE0, 0);
    chk("lit_extra_bresp", 32'(b_got), 32'd2);
    rd(2'd0, BASE + 32'h30, 8'd2, 2'b01, 0, 0);
    chk("lit_extra_unwritten", rd_got[2], 32'h1111_000E);
    wr(2'd2, BASE + 32'h24, 8'd2, 2'b00, 4'hF, 3, 32'hF0, 0);
    rd(2'd3, BASE + 32'h24, 8'd1, 2'b00, 0, 0);
    chk("lit_fixed", rd_got[1], 32'hF2);
    wr(2'd1, BASE + 32'h4, 8'd0, 2'b11, 4'hF, 1, 32'h55, 0);
    chk("lit_rsvd_bresp", 32'(b_got), 32'd2);
    rd(2'd1, BASE + 32'h4, 8'd1, 2'b11, 0, 0);
    rd(2'd1, BASE + 32'h4, 8'd0, 2'b01, 0, 0);
    chk("lit_rsvd_nowrite", rd_got[0], 32'h1111_0001);
    rd(2'd2, BASE + 32'h8, 8'd3, 2'b10, 0, 0);
    chk("lit_wrap_beat2", rd_got[2], WEN ? 32'h0000_CC00 : 32'd1);
    chk("lit_wrap_beat3", rd_got[3], WEN ? 32'h1111_0001 : 32'd2);
    wr(2'd0, BASE + 32'h30, 8'd2, 2'b10, 4'hF, 3, 32'hC0, 0);
    chk("lit_wrap_len2_bresp", 32'(b_got), WEN ? 32'd2 : 32'd0);
    rd(2'd0, BASE + 32'h30, 8'd2, 2'b01, 0, 0);
    // Abandon an 8-beat write after three beats.
    WR_ADDR_ID = 2'd1; WR_ADDR = BASE + 32'h20; WR_ADDR_LEN = 8'd7; WR_ADDR_BURST = 2'b01; WR_ADDR_VALID = 1;
    hs(0, "aw_rst");
    WR_ADDR_VALID = 0;
    for (int i = 0; i < 3; i++) begin
      WR_DATA = 32'hB0 + 32'(i); WR_STRB = 4'hF; WR_DATA_LAST = 0; WR_DATA_VALID = 1;
      mem[8 + i] = 32'hB0 + 32'(i);
      hs(1, "w_rst");
    end
    WR_DATA_VALID = 0;
    RST = 1;
    @(posedge CLK);
    @(negedge CLK) chk_outs_zero("mid_rst");
    @(posedge CLK); #1 RST = 0;
    repeat (4) @(posedge CLK);
    #1 wr(2'd3, BASE + 32'h2C, 8'd0, 2'b01, 4'hF, 1, 32'hC5, 0);
    chk("lit_post_rst_bresp", 32'(b_got), 32'd0);
    rd(2'd3, BASE + 32'h20, 8'd3, 2'b01, 0, 0);
    chk("lit_post_rst_beat0", rd_got[0], 32'hB0);
    chk("lit_post_rst_beat3", rd_got[3], 32'hC5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish within 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
